// File: rtl/main_memory_arbiter_if.sv
// ============================================================================
// main_memory_arbiter_if : requester/memory bundle for main_memory_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface main_memory_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 128
);
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] req_addr;
  logic [2:0]          req_wr;
  logic [8:0]          req_size;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          gnt;
  logic [2:0]          dack;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [2:0]          done;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_en;
  logic                mem_wr;
  logic [2:0]          mem_write_size;
  logic [2:0]          mem_src;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  req, req_addr, req_wr, req_size, req_wdata, mem_rdata,
    output gnt, dack, rvalid, rdata, done,
           mem_addr, mem_en, mem_wr, mem_write_size, mem_src, mem_wdata
  );

  modport master (
    output req, req_addr, req_wr, req_size, req_wdata, mem_rdata,
    input  gnt, dack, rvalid, rdata, done,
           mem_addr, mem_en, mem_wr, mem_write_size, mem_src, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/main_memory_arbiter.sv
// ============================================================================
// main_memory_arbiter : IC/DC/DMA arbiter and beat sequencer for main memory.
// Option macro ARB_ROUND_ROBIN_EN selects rotating priority (default DC>IC>DMA).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module main_memory_arbiter #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 128
) (
  input  logic                 clk,
  input  logic                 clr,
  main_memory_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        owner;
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic [2:0]        size;
  logic              two_beat;
  logic              beat;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        rvalid_q;
  logic [2:0]        dack_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        owner_oh;
  logic [1:0]        win;

  logic [ADDR_W-1:0] src_addr  [3];
  logic [2:0]        src_size  [3];
  logic [DATA_W-1:0] src_wdata [3];

  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign src_addr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign src_size[i]  = bus.req_size[i*3 +: 3];
    assign src_wdata[i] = bus.req_wdata[i*DATA_W +: DATA_W];
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;

  function automatic logic [1:0] mod3_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Walk from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    win = ptr;
    for (int k = 2; k >= 0; k--) begin
      if (bus.req[mod3_add(ptr, 2'(k))]) win = mod3_add(ptr, 2'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (clr)                  ptr <= 2'd1;
    else if (state == S_DONE) ptr <= mod3_add(owner, 2'd1);
  end
`else
  always_comb begin
    if (bus.req[1])      win = 2'd1;
    else if (bus.req[0]) win = 2'd0;
    else                 win = 2'd2;
  end
`endif

  assign owner_oh = 3'b001 << owner;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      owner    <= 2'd0;
      addr     <= '0;
      wr       <= 1'b0;
      size     <= 3'd0;
      two_beat <= 1'b0;
      beat     <= 1'b0;
      cnt      <= '0;
      rvalid_q <= 3'd0;
      dack_q   <= 3'd0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 3'd0;
      dack_q   <= 3'd0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            owner <= win;
            wr    <= bus.req_wr[win];
            size  <= src_size[win];
            beat  <= 1'b0;
            cnt   <= '0;
            state <= S_ACCESS;
            if (src_size[win] == 3'd0) begin
              two_beat <= 1'b1;
              addr     <= {src_addr[win][ADDR_W-1:5], 5'd0};
            end else begin
              two_beat <= 1'b0;
              addr     <= src_addr[win];
            end
          end
        end
        S_ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            if (wr) begin
              dack_q <= owner_oh;
            end else begin
              rvalid_q <= owner_oh;
              rdata_q  <= bus.mem_rdata;
            end
            if (two_beat && !beat) begin
              beat <= 1'b1;
              cnt  <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory pins are driven only while a beat is in flight, so idle/reset reads as all-zero.
  always_comb begin
    bus.gnt            = (state != S_IDLE) ? owner_oh : 3'd0;
    bus.done           = (state == S_DONE) ? owner_oh : 3'd0;
    bus.dack           = dack_q;
    bus.rvalid         = rvalid_q;
    bus.rdata          = rdata_q;
    bus.mem_en         = 1'b0;
    bus.mem_wr         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_size = 3'd0;
    bus.mem_src        = 3'd0;
    bus.mem_wdata      = '0;
    if (state == S_ACCESS) begin
      bus.mem_en         = 1'b1;
      bus.mem_wr         = wr;
      bus.mem_addr       = two_beat ? {addr[ADDR_W-1:5], beat, addr[3:0]} : addr;
      bus.mem_write_size = size;
      bus.mem_src        = {1'b0, owner};
      bus.mem_wdata      = src_wdata[owner];
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_main_memory_arbiter.sv
// ============================================================================
// tb_main_memory_arbiter : scoreboard bench with a transaction-level reference.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_main_memory_arbiter;
  localparam int LATENCY = 4;
  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 128;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  main_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  main_memory_arbiter #(.LATENCY(LATENCY), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    int                kind;   // 0 read beat, 1 write beat, 2 completion
    int                src;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [DATA_W-1:0] data;
    int                beats;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   rr_ptr = 1;

  logic [ADDR_W-1:0] t_addr [3];
  logic              t_wr   [3];
  logic [2:0]        t_size [3];
  logic [DATA_W-1:0] t_wd   [3][2];

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] h;
    h = {17'd0, a} * 32'h9E3779B1;
    return {h, ~h, h ^ 32'hA5A5A5A5, {17'd0, a}};
  endfunction

  assign bus.mem_rdata = mem_word(bus.mem_addr);

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: snapshot memory pins each cycle; a beat response refers to the previous cycle.
  logic [ADDR_W-1:0] s_addr;
  logic              s_en, s_wr;
  logic [2:0]        s_size, s_src;
  logic [DATA_W-1:0] s_wdata;
  int                gcyc = 0;

  always @(negedge clk) begin
    if (clr) begin
      gcyc = 0;
    end else begin
      if (bus.gnt != 3'd0) gcyc++;
      else                 gcyc = 0;
      if (bus.rvalid != 3'd0 || bus.dack != 3'd0) begin
        if (q.size() == 0 || q[0].kind == 2) begin
          total++; bad++;
          $display("FAIL unexpected_beat: rvalid=%b dack=%b expected none", bus.rvalid, bus.dack);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.kind == 0) begin
            chk("rvalid", DATA_W'(bus.rvalid), DATA_W'(3'b001 << e.src));
            chk("rdata", bus.rdata, mem_word(e.addr));
          end else begin
            chk("dack", DATA_W'(bus.dack), DATA_W'(3'b001 << e.src));
            chk("mem_wdata", s_wdata, e.data);
          end
          chk("mem_en", DATA_W'(s_en), DATA_W'(1'b1));
          chk("mem_wr", DATA_W'(s_wr), DATA_W'(e.kind == 1));
          chk("mem_addr", DATA_W'(s_addr), DATA_W'(e.addr));
          chk("mem_size", DATA_W'(s_size), DATA_W'(e.size));
          chk("mem_src", DATA_W'(s_src), DATA_W'(e.src));
        end
      end
      if (bus.done != 3'd0) begin
        if (q.size() == 0 || q[0].kind != 2) begin
          total++; bad++;
          $display("FAIL unexpected_done: done=%b expected none", bus.done);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done", DATA_W'(bus.done), DATA_W'(3'b001 << e.src));
          chk("gnt_at_done", DATA_W'(bus.gnt), DATA_W'(3'b001 << e.src));
          chk("gnt_to_done", DATA_W'(gcyc), DATA_W'(LATENCY * e.beats + 1));
        end
      end
    end
    s_addr  = bus.mem_addr;
    s_en    = bus.mem_en;
    s_wr    = bus.mem_wr;
    s_size  = bus.mem_write_size;
    s_src   = bus.mem_src;
    s_wdata = bus.mem_wdata;
  end

  // Reference arbitration: which pending source the memory serves next.
  function automatic int pick(input logic [2:0] p);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) if (p[(rr_ptr + k) % 3]) return (rr_ptr + k) % 3;
    return 0;
`else
    if (p[1]) return 1;
    if (p[0]) return 0;
    return 2;
`endif
  endfunction

  task automatic serve(input int w);
    int   beats;
    exp_t e;
    beats = (t_size[w] == 3'd0) ? 2 : 1;
    for (int b = 0; b < beats; b++) begin
      e.kind  = t_wr[w] ? 1 : 0;
      e.src   = w;
      e.size  = t_size[w];
      e.addr  = (beats == 2) ? {t_addr[w][ADDR_W-1:5], 1'(b), 4'd0} : t_addr[w];
      e.data  = t_wd[w][b];
      e.beats = beats;
      q.push_back(e);
    end
    e.kind = 2;
    q.push_back(e);
    rr_ptr = (w + 1) % 3;
  endtask

  task automatic load_src(input int s);
    bus.req_addr[s*ADDR_W +: ADDR_W]  = t_addr[s];
    bus.req_wr[s]                     = t_wr[s];
    bus.req_size[s*3 +: 3]            = t_size[s];
    bus.req_wdata[s*DATA_W +: DATA_W] = t_wd[s][0];
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++)
      if (bus.dack[s]) bus.req_wdata[s*DATA_W +: DATA_W] = t_wd[s][1];
  endtask

  task automatic run_round(input logic [2:0] mask);
    logic [2:0] pend, left;
    int n;
    for (int s = 0; s < 3; s++) if (mask[s]) load_src(s);
    pend = mask;
    while (pend != 3'd0) begin
      int w;
      w = pick(pend);
      pend[w] = 1'b0;
      serve(w);
    end
    bus.req = mask;
    left = mask;
    n = 0;
    while (left != 3'd0 && n < 400) begin
      step();
      n++;
      for (int s = 0; s < 3; s++)
        if (bus.done[s]) begin bus.req[s] = 1'b0; left[s] = 1'b0; end
    end
    if (left != 3'd0) begin
      total++; bad++;
      $display("FAIL round_timeout: pending=%b expected 000", left);
      bus.req = 3'd0;
    end
  endtask

  task automatic set_src(input int s, input logic [ADDR_W-1:0] a, input logic w,
                         input logic [2:0] sz, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    t_addr[s] = a; t_wr[s] = w; t_size[s] = sz; t_wd[s][0] = d0; t_wd[s][1] = d1;
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DATA_W-1:0] all_outs();
    return {bus.rdata[DATA_W-1:64] | bus.mem_wdata[DATA_W-1:64],
            bus.rdata[63:0] | bus.mem_wdata[63:0] |
            64'({bus.gnt, bus.dack, bus.rvalid, bus.done, bus.mem_en, bus.mem_wr,
                 bus.mem_write_size, bus.mem_src, bus.mem_addr})};
  endfunction

  logic [2:0] sizes [4] = '{3'd0, 3'd1, 3'd2, 3'd4};

  initial begin
    int n;
    clr = 1'b1;
    bus.req = 3'd0; bus.req_addr = '0; bus.req_wr = 3'd0; bus.req_size = 9'd0; bus.req_wdata = '0;
    repeat (3) step();
    chk("reset_outputs", all_outs(), '0);
    clr = 1'b0;
    step();

    // Reset in the middle of an access aborts it with no completion.
    set_src(1, 15'h0120, 1'b0, 3'd0, '0, '0);
    load_src(1);
    bus.req = 3'b010;
    n = 0;
    while (bus.gnt == 3'd0 && n < 20) begin step(); n++; end
    chk("t1_gnt_seen", DATA_W'(bus.gnt), DATA_W'(3'b010));
    step(); step();
    clr = 1'b1;
    step();
    chk("t1_clr_cycle1", all_outs(), '0);
    step();
    chk("t1_clr_cycle2", all_outs(), '0);
    clr = 1'b0;
    bus.req = 3'd0;
    step();
    chk("t1_idle_after", all_outs(), '0);
    step();
    chk("t1_still_idle", DATA_W'({bus.gnt, bus.done}), '0);

    set_src(1, 15'h0120, 1'b0, 3'd0, '0, '0);
    run_round(3'b010);
    set_src(0, 15'h0043, 1'b1, 3'b010, 128'hBEEF, 128'h0);
    run_round(3'b001);
    for (int s = 0; s < 3; s++) set_src(s, 15'(16'h0200 + 16'(s) * 16'h40), 1'b0, 3'd0, '0, '0);
    run_round(3'b111);
    for (int s = 0; s < 3; s++) set_src(s, 15'($urandom), 1'b0, 3'd4, '0, '0);
    run_round(3'b111);

    // DMA line write drops its request after the first beat; IC arrives while busy.
    set_src(2, 15'h1234, 1'b1, 3'd0, rnd128(), rnd128());
    set_src(0, 15'h0555, 1'b0, 3'd1, '0, '0);
    serve(2);
    serve(0);
    load_src(2);
    load_src(0);
    bus.req = 3'b100;
    n = 0;
    while (bus.dack[2] !== 1'b1 && n < 100) begin step(); n++; end
    chk("t5_first_dack", DATA_W'(n < 100), DATA_W'(1'b1));
    bus.req = 3'b001;
    n = 0;
    while (bus.done[2] !== 1'b1 && n < 100) begin step(); n++; end
    chk("t5_dma_done", DATA_W'(n < 100), DATA_W'(1'b1));
    step();
    chk("t5_idle_gap", DATA_W'(bus.gnt), '0);
    step();
    chk("t5_ic_gnt", DATA_W'(bus.gnt), DATA_W'(3'b001));
    n = 0;
    while (bus.done[0] !== 1'b1 && n < 100) begin step(); n++; end
    chk("t5_ic_done", DATA_W'(n < 100), DATA_W'(1'b1));
    bus.req = 3'd0;

    for (int r = 0; r < 40; r++) begin
      for (int s = 0; s < 3; s++)
        set_src(s, 15'($urandom), 1'($urandom), sizes[$urandom_range(0, 3)], rnd128(), rnd128());
      run_round(3'($urandom_range(1, 7)));
    end

    repeat (3) step();
    chk("queue_drained", DATA_W'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
